// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - pipeline and divider signal bundle for the HI/LO multiply/divide controller
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_start;
  logic        div_sign;
  logic [31:0] div_dividend;
  logic [31:0] div_divider;
  logic        div_ready;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  // Pipeline plus external divider, as seen from outside the controller
  modport master (
    output op_valid, op, rs_val, rt_val, flush, div_ready, div_quotient, div_remainder,
    input  stall, hi, lo, div_start, div_sign, div_dividend, div_divider
  );

  // The controller itself
  modport slave (
    input  op_valid, op, rs_val, rt_val, flush, div_ready, div_quotient, div_remainder,
    output stall, hi, lo, div_start, div_sign, div_dividend, div_divider
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO register controller with single-cycle multiply and iterative divider sequencing
module muldiv_ctrl #(
  parameter int DIV_LATENCY = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [5:0] LAT      = 6'(DIV_LATENCY);

  state_t      state, next_state;
  logic [5:0]  cnt;
  logic [31:0] hi_r, lo_r;
  logic [31:0] opa_r, opb_r;
  logic        sign_r;
  logic        stall_c, start_c, wr_div;

  logic        accept, is_div, rt_zero, div_done;
  logic [63:0] mul_a, mul_b, prod;

  assign accept   = (state == IDLE) && bus.op_valid && !bus.flush;
  assign is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign rt_zero  = (bus.rt_val == 32'd0);
  assign div_done = (cnt == LAT) && bus.div_ready;

  // Signed product uses sign-extended operands; the low 64 bits are then exact.
  assign mul_a = (bus.op == OP_MULT) ? {{32{bus.rs_val[31]}}, bus.rs_val} : {32'd0, bus.rs_val};
  assign mul_b = (bus.op == OP_MULT) ? {{32{bus.rt_val[31]}}, bus.rt_val} : {32'd0, bus.rt_val};
  assign prod  = mul_a * mul_b;

  // State register; reset parks in DRAIN so an interrupted divide runs out first
  always_ff @(posedge clk) begin
    if (rst) state <= DRAIN;
    else     state <= next_state;
  end

  // Next-state, stall and divider start decode; a flush in WAIT kills the write
  always_comb begin
    next_state = state;
    stall_c    = 1'b1;
    start_c    = 1'b0;
    wr_div     = 1'b0;
    case (state)
      IDLE: begin
        stall_c = 1'b0;
        if (accept && is_div && !rt_zero) next_state = START;
      end
      START: begin
        start_c    = 1'b1;
        next_state = bus.flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (bus.flush) begin
          next_state = DRAIN;
        end else if (div_done) begin
          wr_div     = 1'b1;
          next_state = IDLE;
        end
      end
      DRAIN: begin
        if (div_done) next_state = IDLE;
      end
      default: next_state = DRAIN;
    endcase
  end

  // Divider cycle counter: cleared in START, saturating count in WAIT/DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 6'd0;
    end else if (state == START) begin
      cnt <= 6'd0;
    end else if ((state == WAIT || state == DRAIN) && cnt != LAT) begin
      cnt <= cnt + 6'd1;
    end
  end

  // Operand registers feeding the divider, frozen until the divide leaves WAIT/DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r  <= 32'd0;
      opb_r  <= 32'd0;
      sign_r <= 1'b0;
    end else if (accept && is_div && !rt_zero) begin
      opa_r  <= bus.rs_val;
      opb_r  <= bus.rt_val;
      sign_r <= (bus.op == OP_DIV);
    end
  end

  // Architectural HI/LO updates: divider completion or a single-cycle op accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (wr_div) begin
      hi_r <= bus.div_remainder;
      lo_r <= bus.div_quotient;
    end else if (accept) begin
      case (bus.op)
        OP_MULT, OP_MULTU: begin
          hi_r <= prod[63:32];
          lo_r <= prod[31:0];
        end
        OP_MTHI: hi_r <= bus.rs_val;
        OP_MTLO: lo_r <= bus.rs_val;
        OP_DIV, OP_DIVU: begin
          if (rt_zero) begin
            hi_r <= bus.rs_val;
            lo_r <= 32'hFFFF_FFFF;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall        = stall_c;
  assign bus.div_start    = start_c;
  assign bus.div_sign     = sign_r;
  assign bus.div_dividend = opa_r;
  assign bus.div_divider  = opb_r;
  assign bus.hi           = hi_r;
  assign bus.lo           = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.DIV_LATENCY(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [31:0] mq = 32'd0;
  logic [31:0] mr = 32'd0;

  // Behavioural divider: captures operands at start, results held until the next start
  always @(posedge clk) begin
    if (bus.div_start) begin
      if (bus.div_sign) begin
        mq <= $signed(bus.div_dividend) / $signed(bus.div_divider);
        mr <= $signed(bus.div_dividend) % $signed(bus.div_divider);
      end else begin
        mq <= bus.div_dividend / bus.div_divider;
        mr <= bus.div_dividend % bus.div_divider;
      end
    end
  end
  assign bus.div_quotient  = mq;
  assign bus.div_remainder = mr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    step();
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    check(tag, {bus.hi, bus.lo}, e);
  endtask

  // Walk through a stalled divide, optionally flushing at a given stall cycle
  task automatic run_div(input int flush_at, input logic [31:0] rs, input logic [31:0] rt,
                         output int stall_n, output int start_n, output int unstable);
    stall_n  = 0;
    start_n  = 0;
    unstable = 0;
    while (bus.stall && stall_n < 100) begin
      stall_n++;
      if (bus.div_start) start_n++;
      if (bus.div_dividend !== rs || bus.div_divider !== rt) unstable++;
      bus.flush = (stall_n == flush_at);
      step();
    end
    bus.flush = 1'b0;
  endtask

  int n, sn, st, us;

  initial begin
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.flush    = 1'b0;
    bus.div_ready = 1'b1;
    repeat (3) step();
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd1);
    check("rst_div_start", 64'(bus.div_start), 64'd0);
    rst = 1'b0;
    n = 0;
    while (bus.stall && n < 100) begin n++; step(); end
    check("rst_drain_len", 64'(n), 64'd33);

    // MULT / MULTU
    sb.push_back(64'hFFFFFFFF_FFFFFFFE);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    check("mult_stall", 64'(bus.stall), 64'd0);
    pop_check("mult");
    sb.push_back(64'h00000001_FFFFFFFE);
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    check("multu_stall", 64'(bus.stall), 64'd0);
    pop_check("multu");

    // flush after an accepted write, flushed op, reserved op
    bus.flush = 1'b1;
    step();
    sb.push_back(64'h00000001_FFFFFFFE);
    pop_check("flush_after_mult");
    issue(3'd1, 32'd3, 32'd3);
    bus.flush = 1'b0;
    sb.push_back(64'h00000001_FFFFFFFE);
    pop_check("flushed_op");
    issue(3'd7, 32'd9, 32'd9);
    sb.push_back(64'h00000001_FFFFFFFE);
    pop_check("reserved_op");

    // divide by zero
    sb.push_back(64'h00000005_FFFFFFFF);
    issue(3'd3, 32'd5, 32'd0);
    check("div0_stall", 64'(bus.stall), 64'd0);
    check("div0_start", 64'(bus.div_start), 64'd0);
    pop_check("div0");

    // signed DIV -7/2
    sb.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    run_div(-1, 32'hFFFFFFF9, 32'd2, sn, st, us);
    check("div_stall_len", 64'(sn), 64'd34);
    check("div_start_len", 64'(st), 64'd1);
    check("div_opnd_stable", 64'(us), 64'd0);
    pop_check("div_result");

    // DIVU 100/7
    sb.push_back(64'h00000002_0000000E);
    issue(3'd4, 32'd100, 32'd7);
    run_div(-1, 32'd100, 32'd7, sn, st, us);
    check("divu_stall_len", 64'(sn), 64'd34);
    check("divu_opnd_stable", 64'(us), 64'd0);
    pop_check("divu_result");

    // DIV 20/3 flushed at cnt=10 (stall cycle 12)
    sb.push_back(64'h00000002_0000000E);
    issue(3'd3, 32'd20, 32'd3);
    run_div(12, 32'd20, 32'd3, sn, st, us);
    check("flush_stall_len", 64'(sn), 64'd34);
    pop_check("flush_no_write");
    sb.push_back(64'h00000001_00000002);
    issue(3'd4, 32'd9, 32'd4);
    run_div(-1, 32'd9, 32'd4, sn, st, us);
    check("divu94_stall_len", 64'(sn), 64'd34);
    pop_check("divu94_result");

    // reset mid-WAIT, then drain with a late div_ready
    issue(3'd3, 32'd20, 32'd3);
    repeat (10) step();
    rst = 1'b1;
    repeat (2) step();
    check("rst2_hi", 64'(bus.hi), 64'd0);
    check("rst2_lo", 64'(bus.lo), 64'd0);
    check("rst2_stall", 64'(bus.stall), 64'd1);
    check("rst2_div_start", 64'(bus.div_start), 64'd0);
    rst = 1'b0;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      bus.div_ready = (n >= 40);
      step();
    end
    bus.div_ready = 1'b1;
    check("rst2_drain_len", 64'(n), 64'd40);
    sb.push_back(64'h00000000_00001234);
    issue(3'd6, 32'h1234, 32'd0);
    pop_check("mtlo");
    sb.push_back(64'h0000ABCD_00001234);
    issue(3'd5, 32'hABCD, 32'd0);
    pop_check("mthi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
